// File: rtl/pbit_group_sequencer_if.sv
// Handshake/status bundle between the p-bit group sequencer and its controller.
// The master side issues start/stop/num_sweeps; the slave side (the sequencer)
// drives the group select, valid qualifier, sweep strobe and run status.
interface pbit_group_sequencer_if #(
    parameter int unsigned SWEEP_W = 16
);
    logic               start;
    logic               stop;
    logic [SWEEP_W-1:0] num_sweeps;
    logic [0:2]         group_EN;
    logic               group_valid;
    logic               sample_strobe;
    logic [SWEEP_W-1:0] sweep_cnt;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, num_sweeps,
        input  group_EN, group_valid, sample_strobe, sweep_cnt, busy, done
    );

    modport slave (
        input  start, stop, num_sweeps,
        output group_EN, group_valid, sample_strobe, sweep_cnt, busy, done
    );
endinterface

// File: rtl/pbit_group_sequencer.sv
// Grouped p-bit update-order sequencer.
// Walks the 3-bit group select through the colour groups with a programmable
// dwell per group and a one-cycle guard gap between groups, counts sweeps,
// strobes each sweep boundary and ends on a sweep count or a stop request.
// Optional macro PBIT_SEQ_CLAMP_PHASE_EN appends a clamp/readout phase
// (group code 3'b100) at the end of every sweep.
module pbit_group_sequencer #(
    parameter int unsigned NUM_GROUPS = 4,
    parameter int unsigned DWELL      = 8,
    parameter int unsigned SWEEP_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pbit_group_sequencer_if.slave  bus
);
    localparam int unsigned     DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL - 1);
`ifdef PBIT_SEQ_CLAMP_PHASE_EN
    localparam logic [2:0]      LAST_GROUP = 3'(NUM_GROUPS - 1);
    localparam logic [2:0]      LAST_PHASE = 3'b100;
`else
    localparam logic [2:0]      LAST_PHASE = 3'(NUM_GROUPS - 1);
`endif

    typedef enum logic [1:0] {
        st_idle,
        st_update,
        st_gap,
        st_done
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [SWEEP_W-1:0] cnt_q, cnt_d;
    logic [SWEEP_W-1:0] target_q, target_d;
    logic               stop_q, stop_d;
    logic               valid_q, valid_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         idx_next;

    // Phase after the current one; the clamp phase follows the last colour group.
    always_comb begin
`ifdef PBIT_SEQ_CLAMP_PHASE_EN
        idx_next = (idx_q == LAST_GROUP) ? 3'b100 : idx_q + 3'd1;
`else
        idx_next = idx_q + 3'd1;
`endif
    end

    // Next-state and next-output decode. The boundary strobe and count update are
    // issued on entry to the last gap so they appear during that gap cycle; the
    // end-of-run decision is taken during the gap itself.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        stop_d   = stop_q;
        strobe_d = 1'b0;

        if (state_q != st_idle) begin
            stop_d = stop_q | bus.stop;
        end

        case (state_q)
            st_idle: begin
                if (bus.start) begin
                    state_d  = st_update;
                    target_d = bus.num_sweeps;
                    cnt_d    = '0;
                    stop_d   = 1'b0;
                    idx_d    = '0;
                    dwell_d  = DWELL_LOAD;
                end
            end
            st_update: begin
                if (dwell_q == '0) begin
                    state_d = st_gap;
                    if (idx_q == LAST_PHASE) begin
                        strobe_d = 1'b1;
                        cnt_d    = cnt_q + SWEEP_W'(1);
                    end
                end else begin
                    dwell_d = dwell_q - DW_W'(1);
                end
            end
            st_gap: begin
                state_d = st_update;
                dwell_d = DWELL_LOAD;
                if (idx_q != LAST_PHASE) begin
                    idx_d = idx_next;
                end else if (stop_q || bus.stop ||
                             ((target_q != '0) && (cnt_q == target_q))) begin
                    state_d = st_done;
                    idx_d   = '0;
                end else begin
                    idx_d = '0;
                end
            end
            st_done: begin
                state_d = st_idle;
            end
            default: begin
                state_d = st_idle;
            end
        endcase

        valid_d = (state_d == st_update);
        busy_d  = (state_d != st_idle);
        done_d  = (state_d == st_done);
    end

    // State and registered outputs; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= st_idle;
            idx_q    <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            stop_q   <= 1'b0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            stop_q   <= stop_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.group_EN      = idx_q;
    assign bus.group_valid   = valid_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.sweep_cnt     = cnt_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_pbit_group_sequencer.sv
// Self-checking bench for pbit_group_sequencer: a main instance (DWELL=8,
// 16-bit counter) and a narrow instance (DWELL=1, 4-bit counter) for wrap.
module tb_pbit_group_sequencer;
    localparam int unsigned NG = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned W  = 16;
    localparam int unsigned DN = 1;
    localparam int unsigned WN = 4;
`ifdef PBIT_SEQ_CLAMP_PHASE_EN
    localparam int unsigned P = NG + 1;
`else
    localparam int unsigned P = NG;
`endif
    localparam int unsigned L  = P * (D + 1);
    localparam int unsigned LN = P * (DN + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pbit_group_sequencer_if #(.SWEEP_W(W))  bus ();
    pbit_group_sequencer_if #(.SWEEP_W(WN)) wbus ();

    pbit_group_sequencer #(.NUM_GROUPS(NG), .DWELL(D), .SWEEP_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pbit_group_sequencer #(.NUM_GROUPS(NG), .DWELL(DN), .SWEEP_W(WN)) dut_narrow (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Phase position within a sweep maps to colour groups, then the clamp code.
    function automatic int unsigned phase_code(input int unsigned ph);
        return (ph < NG) ? ph : 4;
    endfunction

    // Expected outputs of the main instance at cycle k after the accepted start,
    // for a run that ends after s_end complete sweeps.
    task automatic check_main(input int unsigned k, input int unsigned s_end);
        int unsigned r, ph, pos;
        int unsigned e_code, e_valid, e_strobe, e_cnt, e_busy, e_done;
        if (k <= s_end * L) begin
            r        = (k - 1) % L;
            ph       = r / (D + 1);
            pos      = r % (D + 1);
            e_valid  = (pos < D) ? 1 : 0;
            e_code   = phase_code(ph);
            e_strobe = (r == L - 1) ? 1 : 0;
            e_cnt    = k / L;
            e_busy   = 1;
            e_done   = 0;
        end else begin
            e_valid  = 0;
            e_code   = 0;
            e_strobe = 0;
            e_cnt    = s_end;
            e_busy   = (k == s_end * L + 1) ? 1 : 0;
            e_done   = (k == s_end * L + 1) ? 1 : 0;
        end
        check("group_EN",      32'(bus.group_EN),      e_code);
        check("group_valid",   32'(bus.group_valid),   e_valid);
        check("sample_strobe", 32'(bus.sample_strobe), e_strobe);
        check("sweep_cnt",     32'(bus.sweep_cnt),     e_cnt);
        check("busy",          32'(bus.busy),          e_busy);
        check("done",          32'(bus.done),          e_done);
    endtask

    // One run on the main instance, checked every cycle through the idle return.
    task automatic run_main(input int unsigned n, input int unsigned stopc,
                            input bit spam, input bit stop_with_start);
        int unsigned s_end;
        if (stopc != 0) begin
            s_end = (stopc + L - 1) / L;
            if (n != 0 && n < s_end) s_end = n;
        end else begin
            s_end = n;
        end
        @(negedge clk);
        bus.start      = 1'b1;
        bus.num_sweeps = W'(n);
        bus.stop       = stop_with_start;
        for (int unsigned k = 1; k <= s_end * L + 2; k++) begin
            @(negedge clk);
            check_main(k, s_end);
            bus.stop       = (k == stopc);
            bus.start      = spam && (k <= s_end * L + 1) && ($urandom_range(0, 3) == 0);
            bus.num_sweeps = W'($urandom);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        int unsigned n, stopc, wstop;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.num_sweeps  = '0;
        wbus.start      = 1'b0;
        wbus.stop       = 1'b0;
        wbus.num_sweeps = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst group_EN",      32'(bus.group_EN),      0);
        check("rst group_valid",   32'(bus.group_valid),   0);
        check("rst sample_strobe", 32'(bus.sample_strobe), 0);
        check("rst sweep_cnt",     32'(bus.sweep_cnt),     0);
        check("rst busy",          32'(bus.busy),          0);
        check("rst done",          32'(bus.done),          0);
        rst_n = 1'b1;
        // stop while idle is ignored
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("idle busy", 32'(bus.busy), 0);

        // Counted run of two sweeps
        run_main(2, 0, 1'b0, 1'b0);
        // Free-run, stop somewhere inside sweep 3
        run_main(0, 2 * L + 1 + $urandom_range(0, L - 1), 1'b0, 1'b0);
        // start held/pulsed repeatedly while busy
        run_main(2, 0, 1'b1, 1'b0);
        // start and stop together in idle: stop discarded
        run_main(2, 0, 1'b0, 1'b1);
        // stop exactly on a boundary gap cycle
        run_main(0, 2 * L, 1'b0, 1'b0);

        // Randomized runs
        for (int i = 0; i < 4; i++) begin
            n     = $urandom_range(1, 3);
            stopc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n * L) : 0;
            run_main(n, stopc, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset mid-UPDATE in group 2
        @(negedge clk);
        bus.start      = 1'b1;
        bus.num_sweeps = W'(3);
        for (int unsigned k = 1; k <= 2 * (D + 1) + 3; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_main(k, 3);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst group_EN",      32'(bus.group_EN),      0);
        check("arst group_valid",   32'(bus.group_valid),   0);
        check("arst sample_strobe", 32'(bus.sample_strobe), 0);
        check("arst sweep_cnt",     32'(bus.sweep_cnt),     0);
        check("arst busy",          32'(bus.busy),          0);
        check("arst done",          32'(bus.done),          0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post-rst done", 32'(bus.done), 0);
            check("post-rst busy", 32'(bus.busy), 0);
        end
        run_main(1, 0, 1'b0, 1'b0);

        // Narrow counter: free-run 17 sweeps then stop, count wraps to 1
        @(negedge clk);
        wbus.start      = 1'b1;
        wbus.num_sweeps = '0;
        wstop = 16 * LN + 1 + $urandom_range(0, LN - 1);
        for (int unsigned k = 1; k <= 17 * LN + 2; k++) begin
            @(negedge clk);
            if (k <= 17 * LN) begin
                check("w sweep_cnt", 32'(wbus.sweep_cnt), (k / LN) % 16);
                check("w strobe", 32'(wbus.sample_strobe), (k % LN == 0) ? 1 : 0);
                check("w done", 32'(wbus.done), 0);
            end else if (k == 17 * LN + 1) begin
                check("w final done", 32'(wbus.done), 1);
                check("w final cnt",  32'(wbus.sweep_cnt), 1);
            end else begin
                check("w idle busy", 32'(wbus.busy), 0);
            end
            wbus.start = 1'b0;
            wbus.stop  = (k == wstop);
        end
        wbus.stop = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
